// File: rtl/input_output.sv
// -----------------------------------------------------------------------------
// input_output
//
// Synchronized, optionally debounced "on press" detector for one asynchronous
// level input (push-button, switch). A press that is held for any number of
// cycles produces exactly one single-cycle pulse on `out`. Releases produce
// no pulse.
//
// Data path:
//   in -> SYNC_STAGES-deep synchronizer -> s
//      -> (debouncer, only when INPUT_OUTPUT_DEBOUNCE_EN is defined) -> d
//      -> two-state press FSM -> registered one-cycle pulse on out
//
// Build option:
//   INPUT_OUTPUT_DEBOUNCE_EN  defined   : debouncer present. A changed level on
//                                         s must persist for DEBOUNCE_CYCLES
//                                         consecutive edges before d follows.
//                             undefined : d is a plain wire from s and
//                                         DEBOUNCE_CYCLES has no effect.
//   The port list is the same in both builds.
//
// Parameters:
//   SYNC_STAGES      synchronizer depth, legal 2..4
//   DEBOUNCE_CYCLES  persistence requirement of the debouncer, legal >= 1
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   in           in   raw asynchronous press level, 1 = pressed
//   out          out  registered one-cycle pulse per accepted press
//   state_dbg_o  out  press FSM state (0 = IDLE, 1 = HELD), for observation
//
// Handshake: none. `in` is a free-running level; `out` is a one-cycle strobe
// that the consumer must sample on the clock following its assertion. There is
// no back-pressure: a press is never held off or queued.
// -----------------------------------------------------------------------------
module input_output #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out,
   output logic state_dbg_o
);

   // --------------------------------------------------------------------------
   // Parameter sanity. The block below only exists for illegal settings; it
   // also keeps DEBOUNCE_CYCLES referenced in the build without the debouncer.
   // --------------------------------------------------------------------------
   if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) || (DEBOUNCE_CYCLES < 1)) begin : g_illegal_params
   end

   // --------------------------------------------------------------------------
   // Input synchronizer
   // --------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // --------------------------------------------------------------------------
   // Accepted level d
   // --------------------------------------------------------------------------
   logic d;

`ifdef INPUT_OUTPUT_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   // The counter holds the number of edges s has already disagreed with d.
   // The edge that would make it DEBOUNCE_CYCLES is the accepting edge, so the
   // counter itself never goes beyond DEBOUNCE_CYCLES-1 and cannot wrap.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          lvl_q;
   logic          lvl_d;

   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (s == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
         lvl_d = s;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         lvl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end

   assign d = lvl_q;
`else
   assign d = s;
`endif

   // --------------------------------------------------------------------------
   // Press FSM
   //   IDLE : waiting for a press; d = 1 schedules the pulse and moves to HELD.
   //   HELD : press in progress; stays until d returns to 0.
   // --------------------------------------------------------------------------
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   out_q;
   logic   out_d;

   // State and pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (d) state_d = ST_HELD;
         ST_HELD: if (!d) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pulse is only issued on the IDLE -> HELD move, so a held level cannot
   // retrigger and a release never pulses.
   always_comb begin
      out_d = (state_q == ST_IDLE) && d;
   end

   assign out         = out_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_input_output.sv
// -----------------------------------------------------------------------------
// tb_input_output
//
// Directed steps followed by randomized press/release segments. The reference
// model works at the level of the described behaviour: the synchronizer is a
// fixed delay of SYNC_STAGES samples, the accepted level follows the delayed
// level (after DEBOUNCE_CYCLES disagreeing edges when debounce is built in),
// and a pulse is expected exactly where the accepted level rises.
// -----------------------------------------------------------------------------
module tb_input_output;

   localparam int SYNC = 2;
   localparam int DB   = 4;
`ifdef INPUT_OUTPUT_DEBOUNCE_EN
   localparam int DB_EN = 1;
`else
   localparam int DB_EN = 0;
`endif
   // Edge index (relative to the first high sample) after which out is 1.
   localparam int LAT = SYNC + DB_EN * DB;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic reset;
   logic in_r;
   logic out_w;
   logic state_w;

   always #5 clk = ~clk;

   input_output #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in_r),
      .out         (out_w),
      .state_dbg_o (state_w)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard and reference model
   // ---------------------------------------------------------------------------
   int         n_checks = 0;
   int         n_err    = 0;
   logic [1:0] exp_q[$];     // {expected state, expected out} per edge

   logic       m_pipe[$];    // raw samples still travelling through the synchronizer
   logic       m_d;          // accepted level (debounce build)
   logic       m_dprev;      // accepted level seen at the previous edge
   int         m_run;        // edges the delayed level has disagreed with m_d

   int         edge_n;
   int         pulses;
   int         first_pulse;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pipe.delete();
      for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
      m_d     = 1'b0;
      m_dprev = 1'b0;
      m_run   = 0;
      exp_q.delete();
   endtask

   // One rising edge with raw sample v.
   task automatic model_edge(input logic v);
      logic s_k;
      logic d_k;
      s_k = m_pipe.pop_front();
      m_pipe.push_back(v);
      if (DB_EN != 0) begin
         d_k = m_d;
         if (s_k != m_d) begin
            m_run++;
            if (m_run == DB) begin
               m_d   = s_k;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end else begin
         d_k = s_k;
      end
      exp_q.push_back({d_k, d_k & ~m_dprev});
      m_dprev = d_k;
   endtask

   task automatic mark();
      edge_n      = 0;
      pulses      = 0;
      first_pulse = -1;
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step(input logic v);
      logic [1:0] e;
      in_r = v;
      @(posedge clk);
      model_edge(v);
      #1;
      e = exp_q.pop_front();
      check("out", out_w, e[0]);
      check("state", state_w, e[1]);
      if (out_w === 1'b1) begin
         pulses++;
         if (first_pulse < 0) first_pulse = edge_n;
      end
      edge_n++;
   endtask

   // Hold reset over a few edges with the given input level, then release
   // between edges so the next step's edge is the first one out of reset.
   task automatic apply_reset(input logic v);
      in_r  = v;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("out_in_reset", out_w, 1'b0);
      check("state_in_reset", state_w, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      reset = 1'b1;
      in_r  = 1'b0;
      mark();
      model_reset();
      #2;
      check("out_async_reset", out_w, 1'b0);
      apply_reset(1'b0);

      // Idle input: no pulse, FSM stays IDLE.
      mark();
      hold(1'b0, 4);
      check_int("idle_pulses", pulses, 0);

      // Single press held for 4 samples.
      mark();
      hold(1'b1, 4);
      hold(1'b0, LAT + 4);
      check_int("press_latency", first_pulse, LAT);
      check_int("press_pulses", pulses, 1);

      // Press, release, press: two pulses, none on release.
      mark();
      hold(1'b1, 4);
      hold(1'b0, 4);
      hold(1'b1, 4);
      hold(1'b0, 12);
      check_int("two_press_pulses", pulses, 2);

      // Input held high through reset.
      apply_reset(1'b1);
      mark();
      hold(1'b1, LAT + 3);
      check_int("held_reset_latency", first_pulse, LAT);
      check_int("held_reset_pulses", pulses, 1);
      hold(1'b0, 12);

      // Asynchronous reset while the pulse is high.
      mark();
      hold(1'b1, LAT + 1);
      check("pulse_before_reset", out_w, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("out_async_drop", out_w, 1'b0);
      check("state_async_drop", state_w, 1'b0);
      in_r = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      hold(1'b0, 6);

      // Two-sample glitch: filtered only when debounce is built in.
      mark();
      hold(1'b1, 2);
      hold(1'b0, 12);
      check_int("glitch_pulses", pulses, (DB_EN != 0) ? 0 : 1);

      // Press held for 8 samples.
      mark();
      hold(1'b1, 8);
      hold(1'b0, 12);
      check_int("long_press_latency", first_pulse, LAT);
      check_int("long_press_pulses", pulses, 1);

      // Randomized press/release segments.
      for (int seg = 0; seg < 60; seg++) begin
         logic lvl;
         int   len;
         lvl = logic'($urandom_range(0, 1));
         len = int'($urandom_range(1, 9));
         hold(lvl, len);
      end
      hold(1'b0, 12);
      check_int("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
